// File: rtl/cache_fill_controller.sv
// Miss/store arbiter for the I- and D-caches on the single memory port.
// Ports: clk, rst_n (sync, active-low); i_miss/i_miss_addr,
//   d_miss/d_miss_addr, d_wr/d_wr_addr/d_wr_data (cache side);
//   mem_en/mem_wr/mem_addr/mem_wdata out, mem_rdata/mem_data_valid in;
//   i/d_fill_we, fill_word_idx, fill_data, i/d_tag_we, fill_block_addr,
//   fill_done (cache refill writes); i_busy/d_busy (pipeline stall).
// The fill counts returned beats, so it works for any in-order latency.
module cache_fill_controller #(
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_miss,
    input  logic [15:0]                        i_miss_addr,
    input  logic                               d_miss,
    input  logic [15:0]                        d_miss_addr,
    input  logic                               d_wr,
    input  logic [15:0]                        d_wr_addr,
    input  logic [15:0]                        d_wr_data,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [15:0]                        mem_addr,
    output logic [15:0]                        mem_wdata,
    input  logic [15:0]                        mem_rdata,
    input  logic                               mem_data_valid,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic [15:0]                        fill_data,
    output logic                               i_tag_we,
    output logic                               d_tag_we,
    output logic [15:0]                        fill_block_addr,
    output logic                               i_busy,
    output logic                               d_busy,
    output logic                               fill_done
);

    localparam int IW = $clog2(WORDS_PER_BLOCK);
    localparam int CW = $clog2(WORDS_PER_BLOCK + 1);
    localparam logic [CW-1:0] NWORDS = CW'(WORDS_PER_BLOCK);
    localparam logic [CW-1:0] LASTW  = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [15:0]   BLK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        I_FILL,
        D_FILL,
        WRITE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  iss_q, iss_d;
    logic [CW-1:0]  rcv_q, rcv_d;
    logic [15:0]    blk_q, blk_d;
    logic [15:0]    wa_q, wa_d;
    logic [15:0]    wd_q, wd_d;

    logic fill_act;
    logic issue;
    logic beat;
    logic last;

    assign fill_act = (state_q == I_FILL) || (state_q == D_FILL);
    assign issue    = fill_act && (iss_q < NWORDS);
    // Beats outside a fill (spurious or from an aborted fill) are dropped.
    assign beat     = fill_act && mem_data_valid;
    assign last     = beat && (rcv_q == LASTW);

    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        rcv_d   = rcv_q;
        blk_d   = blk_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                // D side first: it is older in the pipeline.
                if (d_miss) begin
                    state_d = D_FILL;
                    blk_d   = d_miss_addr & BLK_MASK;
                    iss_d   = '0;
                    rcv_d   = '0;
                end else if (d_wr) begin
                    state_d = WRITE;
                    wa_d    = d_wr_addr;
                    wd_d    = d_wr_data;
                end else if (i_miss) begin
                    state_d = I_FILL;
                    blk_d   = i_miss_addr & BLK_MASK;
                    iss_d   = '0;
                    rcv_d   = '0;
                end
            end
            I_FILL, D_FILL: begin
                if (issue) iss_d = iss_q + 1'b1;
                if (beat)  rcv_d = rcv_q + 1'b1;
                if (last)  state_d = IDLE;
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iss_q   <= '0;
            rcv_q   <= '0;
            blk_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            blk_q   <= blk_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = wa_q;
            mem_wdata = wd_q;
        end else if (issue) begin
            mem_en   = 1'b1;
            mem_addr = blk_q + 16'({iss_q, 1'b0});
        end
    end

    assign fill_data       = mem_rdata;
    assign fill_word_idx   = rcv_q[IW-1:0];
    assign fill_block_addr = blk_q;
    assign i_fill_we       = beat && (state_q == I_FILL);
    assign d_fill_we       = beat && (state_q == D_FILL);
    assign i_tag_we        = last && (state_q == I_FILL);
    assign d_tag_we        = last && (state_q == D_FILL);
    assign fill_done       = last;

    // A pending I miss stalls in every state other than its own fill
    // too, so this reduces to "filling I, or an I miss is pending".
    assign i_busy = (state_q == I_FILL) || i_miss;
    assign d_busy = (state_q == D_FILL) || (state_q == WRITE) ||
                    ((state_q == IDLE) && (d_miss || d_wr));

endmodule

// File: tb/tb_cache_fill_controller.sv
// Bench for cache_fill_controller: 4-cycle in-order memory model plus
// scoreboard queues of expected requests, fill writes and tag writes.
module tb_cache_fill_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0;
    logic [15:0] d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic        i_fill_we, d_fill_we;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic        i_tag_we, d_tag_we;
    logic [15:0] fill_block_addr;
    logic        i_busy, d_busy, fill_done;

    cache_fill_controller #(.WORDS_PER_BLOCK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .fill_word_idx(fill_word_idx), .fill_data(fill_data),
        .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
        .fill_block_addr(fill_block_addr),
        .i_busy(i_busy), .d_busy(d_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } rq_t;
    typedef struct {
        int          cyc;
        logic        side;
        logic [2:0]  idx;
        logic [15:0] data;
    } fq_t;
    typedef struct {
        int          cyc;
        logic        side;
        logic [15:0] blk;
    } tq_t;

    rq_t rq[$];
    fq_t fq[$];
    tq_t tq[$];

    // side: 0 = I, 1 = D; t = cycle the miss is arbitrated in IDLE
    task automatic push_fill(input int t, input logic side,
                             input logic [15:0] addr);
        logic [15:0] b;
        logic [15:0] a;
        b = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            a = b + 16'(2 * k);
            rq.push_back('{t + 1 + k, 1'b0, a, 16'h0});
            fq.push_back('{t + 5 + k, side, 3'(k), mdata(a)});
        end
        tq.push_back('{t + 12, side, b});
    endtask

    // memory: read requests return mdata(addr) four cycles later
    logic        mv[4];
    logic [15:0] ma[4];
    logic        cur_v;
    logic [15:0] cur_a;
    logic        spur = 1'b0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            ma[i] = '0;
        end
        mem_data_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cur_v = (mem_en === 1'b1) && (mem_wr === 1'b0);
            cur_a = mem_addr;
            @(posedge clk);
            #2;
            for (int i = 3; i > 0; i--) begin
                mv[i] = mv[i-1];
                ma[i] = ma[i-1];
            end
            mv[0] = cur_v;
            ma[0] = cur_a;
            mem_data_valid = mv[3] | spur;
            mem_rdata = mv[3] ? mdata(ma[3]) : (spur ? 16'hDEAD : 16'h0);
        end
    end

    logic mon_on = 1'b0;

    initial begin
        rq_t r;
        fq_t f;
        tq_t t;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (mem_en === 1'b1) begin
                    check("rq_avail", rq.size() > 0, 1);
                    if (rq.size() > 0) begin
                        r = rq.pop_front();
                        check("rq_cyc", cyc, r.cyc);
                        check("rq_wr", mem_wr, r.wr);
                        check("rq_addr", mem_addr, r.addr);
                        if (r.wr) check("rq_wdata", mem_wdata, r.data);
                    end
                end
                if (i_fill_we !== 1'b0 || d_fill_we !== 1'b0) begin
                    check("fq_avail", fq.size() > 0, 1);
                    if (fq.size() > 0) begin
                        f = fq.pop_front();
                        check("fill_cyc", cyc, f.cyc);
                        check("fill_side", {i_fill_we, d_fill_we},
                              f.side ? 2'b01 : 2'b10);
                        check("fill_idx", fill_word_idx, f.idx);
                        check("fill_data", fill_data, f.data);
                    end
                end
                if (i_tag_we !== 1'b0 || d_tag_we !== 1'b0 ||
                    fill_done !== 1'b0) begin
                    check("tq_avail", tq.size() > 0, 1);
                    if (tq.size() > 0) begin
                        t = tq.pop_front();
                        check("tag_cyc", cyc, t.cyc);
                        check("tag_side", {i_tag_we, d_tag_we, fill_done},
                              t.side ? 3'b011 : 3'b101);
                        check("tag_blk", fill_block_addr, t.blk);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem"}, {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
        check({tag, "_we"}, {i_fill_we, d_fill_we, i_tag_we, d_tag_we}, 0);
        check({tag, "_idx"}, fill_word_idx, 0);
        check({tag, "_blk"}, fill_block_addr, 0);
        check({tag, "_busy"}, {i_busy, d_busy, fill_done}, 0);
    endtask

    initial begin
        int t0;
        int t1;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check_all_zero("rst");

        // I miss at 0x1236
        tick();
        t0 = cyc;
        i_miss_addr = 16'h1236;
        i_miss = 1'b1;
        push_fill(t0, 1'b0, 16'h1236);
        @(negedge clk);
        check("s1_ibusy_c0", i_busy, 1);
        check("s1_dbusy_c0", d_busy, 0);
        repeat (12) tick();
        @(negedge clk);
        check("s1_ibusy_c12", i_busy, 1);
        tick();
        i_miss = 1'b0;
        @(negedge clk);
        check("s1_ibusy_c13", i_busy, 0);

        // D miss and I miss together: D first, I right after
        tick();
        t0 = cyc;
        d_miss_addr = 16'h4008;
        i_miss_addr = 16'h0010;
        d_miss = 1'b1;
        i_miss = 1'b1;
        push_fill(t0, 1'b1, 16'h4008);
        push_fill(t0 + 13, 1'b0, 16'h0010);
        @(negedge clk);
        check("s2_dbusy_c0", d_busy, 1);
        check("s2_ibusy_c0", i_busy, 1);
        repeat (6) tick();
        @(negedge clk);
        check("s2_ibusy_dfill", i_busy, 1);
        repeat (7) tick();
        d_miss = 1'b0;
        @(negedge clk);
        check("s2_dbusy_c13", d_busy, 0);
        check("s2_ibusy_c13", i_busy, 1);
        repeat (13) tick();
        i_miss = 1'b0;
        @(negedge clk);
        check("s2_ibusy_c26", i_busy, 0);

        // write-through store
        tick();
        t0 = cyc;
        d_wr_addr = 16'h2002;
        d_wr_data = 16'hBEEF;
        d_wr = 1'b1;
        rq.push_back('{t0 + 1, 1'b1, 16'h2002, 16'hBEEF});
        @(negedge clk);
        check("s3_dbusy_c0", d_busy, 1);
        tick();
        d_wr = 1'b0;
        @(negedge clk);
        check("s3_dbusy_c1", d_busy, 1);
        tick();
        @(negedge clk);
        check("s3_dbusy_c2", d_busy, 0);
        check("s3_memen_c2", mem_en, 0);

        // store and I miss together
        tick();
        t0 = cyc;
        d_wr_addr = 16'h2A10;
        d_wr_data = 16'h1234;
        d_wr = 1'b1;
        i_miss_addr = 16'h7FFE;
        i_miss = 1'b1;
        rq.push_back('{t0 + 1, 1'b1, 16'h2A10, 16'h1234});
        push_fill(t0 + 2, 1'b0, 16'h7FFE);
        @(negedge clk);
        check("s4_ibusy_c0", i_busy, 1);
        check("s4_dbusy_c0", d_busy, 1);
        tick();
        d_wr = 1'b0;
        @(negedge clk);
        check("s4_ibusy_c1", i_busy, 1);
        check("s4_dbusy_c1", d_busy, 1);
        tick();
        @(negedge clk);
        check("s4_ibusy_c2", i_busy, 1);
        check("s4_dbusy_c2", d_busy, 0);
        repeat (13) tick();
        i_miss = 1'b0;
        @(negedge clk);
        check("s4_ibusy_end", i_busy, 0);

        // reset in cycle 7 of a D fill; late beats must be dropped
        tick();
        t0 = cyc;
        d_miss_addr = 16'h6004;
        d_miss = 1'b1;
        for (int k = 0; k < 7; k++)
            rq.push_back('{t0 + 1 + k, 1'b0, 16'h6000 + 16'(2 * k), 16'h0});
        for (int k = 0; k < 3; k++)
            fq.push_back('{t0 + 5 + k, 1'b1, 3'(k),
                           mdata(16'h6000 + 16'(2 * k))});
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        d_miss = 1'b0;
        @(negedge clk);
        check_all_zero("s5_abort");
        repeat (5) tick();
        t1 = cyc;
        d_miss_addr = 16'h6010;
        d_miss = 1'b1;
        push_fill(t1, 1'b1, 16'h6010);
        repeat (13) tick();
        d_miss = 1'b0;
        @(negedge clk);
        check("s5_dbusy_end", d_busy, 0);

        // spurious valid in IDLE, then a fill at the top of a block
        tick();
        spur = 1'b1;
        @(negedge clk);
        check("s6_spur_we", {i_fill_we, d_fill_we, i_tag_we, d_tag_we}, 0);
        check("s6_spur_busy", {i_busy, d_busy, mem_en}, 0);
        repeat (2) tick();
        @(negedge clk);
        check("s6_spur_done", fill_done, 0);
        tick();
        spur = 1'b0;
        tick();
        t0 = cyc;
        i_miss_addr = 16'h0FFE;
        i_miss = 1'b1;
        push_fill(t0, 1'b0, 16'h0FFE);
        repeat (13) tick();
        i_miss = 1'b0;
        @(negedge clk);
        check("s6_ibusy_end", i_busy, 0);

        repeat (6) tick();
        check("rq_left", rq.size(), 0);
        check("fq_left", fq.size(), 0);
        check("tq_left", tq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
